// File: rtl/accelerator_transformer_matrix_transpose.sv
// Streaming matrix transposer. A SIZE_I x SIZE_J matrix is written row-major into
// an internal buffer, then read back column-major one element per cycle.
module accelerator_transformer_matrix_transpose #(
  parameter int unsigned DATA_SIZE  = 64,
  parameter int unsigned INDEX_SIZE = 7,
  parameter int unsigned MAX_SIZE   = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [INDEX_SIZE-1:0] SIZE_I_IN,
  input  logic [INDEX_SIZE-1:0] SIZE_J_IN,
  input  logic                  DATA_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]  DATA_IN,
  output logic                  READY,
  output logic                  DATA_IN_READY,
  output logic                  DATA_OUT_I_ENABLE,
  output logic                  DATA_OUT_J_ENABLE,
  output logic [DATA_SIZE-1:0]  DATA_OUT
);

  localparam int unsigned AddrW = $clog2(MAX_SIZE * MAX_SIZE);
  localparam logic [INDEX_SIZE-1:0] MaxIdx = INDEX_SIZE'(MAX_SIZE);
  localparam logic [INDEX_SIZE-1:0] One    = INDEX_SIZE'(1);

  typedef enum logic [1:0] {StIdle, StLoad, StEmit} state_e;

  state_e                state_q, state_d;
  logic [INDEX_SIZE-1:0] si_q, si_d, sj_q, sj_d;
  logic [INDEX_SIZE-1:0] i_q, i_d, j_q, j_d;
  logic [INDEX_SIZE-1:0] r_q, r_d, c_q, c_d;
  logic                  ready_q, ready_d;
  logic                  din_ready_q, din_ready_d;
  logic                  oi_en_q, oi_en_d;
  logic                  oj_en_q, oj_en_d;
  logic [DATA_SIZE-1:0]  dout_q, dout_d;
  // Set once the final element has been presented; the next edge returns to idle.
  logic                  last_q, last_d;

  logic [DATA_SIZE-1:0]  mem_q [MAX_SIZE*MAX_SIZE];
  logic [AddrW-1:0]      wr_addr, rd_addr;
  logic                  wr_en;
  logic                  size_ok;

  assign wr_addr = AddrW'(32'(i_q) * MAX_SIZE + 32'(j_q));
  assign rd_addr = AddrW'(32'(c_q) * MAX_SIZE + 32'(r_q));
  assign size_ok = (SIZE_I_IN != '0) && (SIZE_J_IN != '0) &&
                   (SIZE_I_IN <= MaxIdx) && (SIZE_J_IN <= MaxIdx);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    si_d        = si_q;
    sj_d        = sj_q;
    i_d         = i_q;
    j_d         = j_q;
    r_d         = r_q;
    c_d         = c_q;
    ready_d     = ready_q;
    din_ready_d = din_ready_q;
    oi_en_d     = oi_en_q;
    oj_en_d     = oj_en_q;
    dout_d      = dout_q;
    last_d      = last_q;
    wr_en       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!ready_q) begin
          // Recover from a rejected START after exactly one cycle.
          ready_d = 1'b1;
        end else if (START) begin
          si_d    = SIZE_I_IN;
          sj_d    = SIZE_J_IN;
          i_d     = '0;
          j_d     = '0;
          r_d     = '0;
          c_d     = '0;
          last_d  = 1'b0;
          ready_d = 1'b0;
          if (size_ok) begin
            state_d     = StLoad;
            din_ready_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (DATA_IN_ENABLE) begin
          wr_en = 1'b1;
          if (j_q == sj_q - One) begin
            j_d = '0;
            if (i_q == si_q - One) begin
              i_d         = '0;
              state_d     = StEmit;
              din_ready_d = 1'b0;
            end else begin
              i_d = i_q + One;
            end
          end else begin
            j_d = j_q + One;
          end
        end
      end
      StEmit: begin
        if (last_q) begin
          state_d = StIdle;
          oj_en_d = 1'b0;
          oi_en_d = 1'b0;
          ready_d = 1'b1;
          last_d  = 1'b0;
        end else begin
          dout_d  = mem_q[rd_addr];
          oj_en_d = 1'b1;
          oi_en_d = (c_q == '0);
          if (c_q == si_q - One) begin
            c_d = '0;
            if (r_q == sj_q - One) begin
              last_d = 1'b1;
            end else begin
              r_d = r_q + One;
            end
          end else begin
            c_d = c_q + One;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      si_q        <= '0;
      sj_q        <= '0;
      i_q         <= '0;
      j_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      ready_q     <= 1'b1;
      din_ready_q <= 1'b0;
      oi_en_q     <= 1'b0;
      oj_en_q     <= 1'b0;
      dout_q      <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      i_q         <= i_d;
      j_q         <= j_d;
      r_q         <= r_d;
      c_q         <= c_d;
      ready_q     <= ready_d;
      din_ready_q <= din_ready_d;
      oi_en_q     <= oi_en_d;
      oj_en_q     <= oj_en_d;
      dout_q      <= dout_d;
      last_q      <= last_d;
    end
  end

  // Element buffer; intentionally not reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_addr] <= DATA_IN;
    end
  end

  assign READY             = ready_q;
  assign DATA_IN_READY     = din_ready_q;
  assign DATA_OUT_I_ENABLE = oi_en_q;
  assign DATA_OUT_J_ENABLE = oj_en_q;
  assign DATA_OUT          = dout_q;

endmodule

// File: tb/tb_accelerator_transformer_matrix_transpose.sv
// Directed bench for the matrix transposer.
module tb_accelerator_transformer_matrix_transpose;

  localparam int DW = 64;
  localparam int IW = 7;

  typedef logic [63:0] q_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [IW-1:0] size_i = '0;
  logic [IW-1:0] size_j = '0;
  logic          din_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          ready, din_ready, oi_en, oj_en;
  logic [DW-1:0] dout;

  int n_checks = 0;
  int n_errors = 0;

  accelerator_transformer_matrix_transpose #(
    .DATA_SIZE (DW),
    .INDEX_SIZE(IW),
    .MAX_SIZE  (64)
  ) dut (
    .CLK              (clk),
    .RST              (rst_n),
    .START            (start),
    .SIZE_I_IN        (size_i),
    .SIZE_J_IN        (size_j),
    .DATA_IN_ENABLE   (din_en),
    .DATA_IN          (din),
    .READY            (ready),
    .DATA_IN_READY    (din_ready),
    .DATA_OUT_I_ENABLE(oi_en),
    .DATA_OUT_J_ENABLE(oj_en),
    .DATA_OUT         (dout)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an operation and stream in values; gaps insert an idle cycle before each
  // element, noise pulses START with other sizes while loading.
  task automatic load(input int si, input int sj, input q_t vals, input bit gaps,
                      input bit noise);
    size_i = IW'(si);
    size_j = IW'(sj);
    start  = 1'b1;
    tick();
    start = 1'b0;
    check("load_rdy", din_ready, 1);
    check("ready_low", ready, 0);
    foreach (vals[k]) begin
      if (gaps) begin
        din_en = 1'b0;
        din    = '1;
        tick();
        check("gap_rdy", din_ready, 1);
      end
      din_en = 1'b1;
      din    = vals[k];
      if (noise) begin
        start  = 1'b1;
        size_i = 3;
        size_j = 3;
      end
      tick();
    end
    din_en = 1'b0;
    start  = 1'b0;
    check("load_done_rdy", din_ready, 0);
    check("no_early_out", oj_en, 0);
  endtask

  // Expect the transposed stream on consecutive cycles, then a clean return to idle.
  task automatic emit(input int si, input q_t exp, input bit noise);
    foreach (exp[k]) begin
      if (noise) begin
        din_en = 1'b1;
        din    = 64'hDEAD_0000 + 64'(k);
        start  = 1'b1;
      end
      tick();
      check("oj", oj_en, 1);
      check("dout", dout, exp[k]);
      check("oi", oi_en, 64'((k % si) == 0));
    end
    din_en = 1'b0;
    start  = 1'b0;
    tick();
    check("end_oj", oj_en, 0);
    check("end_oi", oi_en, 0);
    check("end_ready", ready, 1);
    check("dout_hold", dout, exp[exp.size()-1]);
  endtask

  task automatic bad_size(input int si, input int sj);
    size_i = IW'(si);
    size_j = IW'(sj);
    start  = 1'b1;
    din_en = 1'b1;
    tick();
    start = 1'b0;
    check("bad_ready_low", ready, 0);
    check("bad_no_load", din_ready, 0);
    check("bad_no_out", oj_en, 0);
    tick();
    check("bad_ready_back", ready, 1);
    check("bad_no_load2", din_ready, 0);
    check("bad_no_out2", oj_en, 0);
    din_en = 1'b0;
    tick();
    check("bad_no_load3", din_ready, 0);
  endtask

  initial begin
    q_t vals, exp;
    #12;
    check("rst_ready", ready, 1);
    check("rst_din_rdy", din_ready, 0);
    check("rst_oi", oi_en, 0);
    check("rst_oj", oj_en, 0);
    check("rst_dout", dout, 0);
    #10 rst_n = 1'b1;
    tick();

    // Basic 2x3.
    vals = '{1, 2, 3, 4, 5, 6};
    exp  = '{1, 4, 2, 5, 3, 6};
    load(2, 3, vals, 1'b0, 1'b0);
    emit(2, exp, 1'b0);

    // Gapped 3x2.
    vals = '{10, 11, 12, 13, 14, 15};
    exp  = '{10, 12, 14, 11, 13, 15};
    load(3, 2, vals, 1'b1, 1'b0);
    emit(3, exp, 1'b0);

    // 1x1.
    vals = '{64'hA5};
    exp  = '{64'hA5};
    load(1, 1, vals, 1'b0, 1'b0);
    emit(1, exp, 1'b0);

    // 1x4: I_ENABLE on every element; 4x1: only once.
    vals = '{7, 8, 9, 10};
    exp  = '{7, 8, 9, 10};
    load(1, 4, vals, 1'b0, 1'b0);
    emit(1, exp, 1'b0);
    load(4, 1, vals, 1'b0, 1'b0);
    emit(4, exp, 1'b0);

    // Rejected sizes.
    bad_size(0, 4);
    bad_size(65, 4);
    bad_size(4, 0);

    // START and DATA_IN_ENABLE noise during LOAD and EMIT.
    vals = '{1, 2, 3, 4};
    exp  = '{1, 3, 2, 4};
    load(2, 2, vals, 1'b0, 1'b1);
    emit(2, exp, 1'b1);

    // Reset after three outputs of a 4x4.
    vals = '{};
    for (int k = 1; k <= 16; k++) vals.push_back(64'(k));
    load(4, 4, vals, 1'b0, 1'b0);
    exp = '{1, 5, 9};
    foreach (exp[k]) begin
      tick();
      check("pre_rst_dout", dout, exp[k]);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_oj", oj_en, 0);
    check("midrst_oi", oi_en, 0);
    check("midrst_ready", ready, 1);
    check("midrst_dout", dout, 0);
    #2 rst_n = 1'b1;
    tick();
    check("postrst_oj", oj_en, 0);
    check("postrst_ready", ready, 1);
    vals = '{1, 2, 3, 4};
    exp  = '{1, 3, 2, 4};
    load(2, 2, vals, 1'b0, 1'b0);
    emit(2, exp, 1'b0);

    // 64x64 with value i*64+j.
    vals = '{};
    exp  = '{};
    for (int k = 0; k < 4096; k++) begin
      vals.push_back(64'(k));
      exp.push_back(64'((k % 64) * 64 + k / 64));
    end
    load(64, 64, vals, 1'b0, 1'b0);
    emit(64, exp, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/accelerator_transformer_matrix_transpose.md
Name: accelerator_transformer_matrix_transpose

Overview:
- Streaming matrix transposer for the standard transformer accelerator. It produces K^T for the Q·K^T stage and also serves any other transformer operand reorder.
- A producer writes a row-major SIZE_I×SIZE_J matrix, one element per strobe.
- The block then reads the matrix back column-major, one element per cycle, as a row-major SIZE_J×SIZE_I stream.
- Sits between the projection datapath (writer) and the attention-score datapath (reader).

Parameters:
- DATA_SIZE, 64, element width in bits.
- INDEX_SIZE, 7, width of size/index ports; must hold MAX_SIZE.
- MAX_SIZE, 64, maximum rows/columns held in the internal buffer (MAX_SIZE×MAX_SIZE×DATA_SIZE storage).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- START  in  1  begin operation; sampled only in IDLE.
- SIZE_I_IN  in  INDEX_SIZE  input row count, latched on START.
- SIZE_J_IN  in  INDEX_SIZE  input column count, latched on START.
- DATA_IN_ENABLE  in  1  DATA_IN valid strobe.
- DATA_IN  in  DATA_SIZE  input element, row-major order.
- READY  out  1  high when IDLE and able to accept START.
- DATA_IN_READY  out  1  high while in LOAD.
- DATA_OUT_I_ENABLE  out  1  pulses on the first element of each output row.
- DATA_OUT_J_ENABLE  out  1  DATA_OUT valid.
- DATA_OUT  out  DATA_SIZE  transposed element.

Behaviour:
- Reset (RST=0, async):
  - state=IDLE, READY=1, DATA_IN_READY=0, DATA_OUT_I_ENABLE=0, DATA_OUT_J_ENABLE=0, DATA_OUT=0, all counters=0.
  - Buffer contents are not cleared.
  - Reset asserted mid-LOAD or mid-EMIT aborts immediately; no further output.
- All outputs are registered.
- FSM states: IDLE, LOAD, EMIT.
- IDLE:
  - START=1 latches SI=SIZE_I_IN and SJ=SIZE_J_IN, clears i/j counters, drives READY=0.
  - If SI=0, SJ=0, SI>MAX_SIZE or SJ>MAX_SIZE: the next state is IDLE, READY drops for exactly one cycle, and no data is accepted or emitted.
  - Otherwise the next state is LOAD and DATA_IN_READY=1.
  - DATA_IN_ENABLE is ignored in IDLE, including in the same cycle as START.
- LOAD:
  - Each cycle with DATA_IN_ENABLE=1 writes buf[i][j]=DATA_IN.
  - Counter update: j++; when j=SJ-1, j wraps to 0 and i++.
  - Gaps (DATA_IN_ENABLE=0) hold the counters.
  - The write of element (SI-1,SJ-1) moves the FSM to EMIT and deasserts DATA_IN_READY on the same edge.
  - START is ignored.
- EMIT:
  - Output counters r in 0..SJ-1 (outer) and c in 0..SI-1 (inner).
  - Each cycle: DATA_OUT=buf[c][r], DATA_OUT_J_ENABLE=1, DATA_OUT_I_ENABLE=(c==0).
  - The first output is visible the cycle after the last input edge, i.e. latency 1 cycle from final write.
  - Exactly SI×SJ consecutive output cycles; no backpressure.
  - After element (r=SJ-1,c=SI-1) is presented, next state is IDLE.
  - On return to IDLE: DATA_OUT_J_ENABLE=0, DATA_OUT_I_ENABLE=0, READY=1. DATA_OUT holds its last value.
  - DATA_IN_ENABLE and START are ignored in EMIT.
- 1×N and N×1 matrices:
  - I_ENABLE pulses on every element when SI=1.
  - I_ENABLE pulses only once when SJ=1.
- Back-to-back operation: START is accepted on the first cycle READY=1 after EMIT. The new operation overwrites buffer entries; no stale data is emitted.

Test Plan:
- Basic 2×3: START with SI=2, SJ=3; DATA_IN=1,2,3,4,5,6 on consecutive cycles -> DATA_OUT=1,4,2,5,3,6 on 6 consecutive cycles. I_ENABLE is high with 1, 2 and 3. READY=1 one cycle after the last output.
- Gapped input 3×2: values 10..15 with DATA_IN_ENABLE low every other cycle -> output 10,12,14,11,13,15 with no gaps. First output appears one cycle after the write of 15.
- Degenerate sizes:
  - SI=1, SJ=1, value 0xA5 -> single output 0xA5 with I_ENABLE=1 and J_ENABLE=1.
  - SI=0, SJ=4 -> READY low exactly one cycle; DATA_IN_READY and J_ENABLE never assert.
  - SI=65 -> same as the SI=0 case.
- Ignored controls:
  - START pulsed during LOAD and EMIT of a 2×2 (values 1..4) -> output is still 1,3,2,4 and sizes are unchanged.
  - DATA_IN_ENABLE during EMIT does not corrupt the output.
- Reset mid-EMIT: assert RST=0 after 3 outputs of a 4×4 -> same-cycle J_ENABLE=0, READY=1. A following 2×2 (values 1..4) emits 1,3,2,4 with no leftover 4×4 data.
- Max size: a 64×64 matrix with value = i*64+j -> output k equals (k%64)*64+k/64 for all 4096 cycles. I_ENABLE is high every 64th cycle starting at k=0.
